// File: rtl/exc_commit.sv
// Exception commit at the MEM/WB boundary: prioritises exception flags
// and pending interrupts, and issues one-cycle CP0 strobes and flushes.
//
// Ports:
//   clk, resetn             clock, async active-low reset
//   cm_valid / cm_ready     commit handshake; accept = cm_valid & cm_ready
//   cm_*                    committing instruction: pc, bd, exception flags,
//                           data address, eret, mtc0 address and data
//   div_busy                divide in flight; commit of a fault waits on it
//   status_*, cause_ip      CP0 state used to detect a pending interrupt
//   epc_in                  current EPC, used as the eret redirect target
//   cp0_ex, cp0_excode,
//   cp0_bd, cp0_pc,
//   cp0_badvaddr            exception strobe and its fields
//   eret_flush              eret strobe
//   cp0_we, cp0_addr,
//   cp0_wdata               mtc0 write strobe
//   flush, flush_pc         pipeline flush and redirect target
//   exc_cnt                 saturating count of exception strobes
module exc_commit #(
    parameter logic [31:0] EX_VEC = 32'hBFC00380
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cm_valid,
    output logic        cm_ready,
    input  logic [31:0] cm_pc,
    input  logic        cm_bd,
    input  logic        cm_adel_if,
    input  logic        cm_ri,
    input  logic        cm_ov,
    input  logic        cm_sys,
    input  logic        cm_bp,
    input  logic        cm_adel_ld,
    input  logic        cm_ades_st,
    input  logic [31:0] cm_daddr,
    input  logic        cm_eret,
    input  logic        cm_mtc0,
    input  logic [4:0]  cm_cp0_addr,
    input  logic [31:0] cm_cp0_wdata,
    input  logic        div_busy,
    input  logic        status_ie,
    input  logic        status_exl,
    input  logic [7:0]  status_im,
    input  logic [7:0]  cause_ip,
    input  logic [31:0] epc_in,
    output logic        cp0_ex,
    output logic [4:0]  cp0_excode,
    output logic        cp0_bd,
    output logic [31:0] cp0_pc,
    output logic [31:0] cp0_badvaddr,
    output logic        eret_flush,
    output logic        cp0_we,
    output logic [4:0]  cp0_addr,
    output logic [31:0] cp0_wdata,
    output logic        flush,
    output logic [31:0] flush_pc,
    output logic [15:0] exc_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DIV,
        FLUSH
    } state_t;

    state_t      state;

    logic        int_pend;
    logic        has_exc;
    logic [4:0]  code_d;
    logic [31:0] badv_d;

    logic [31:0] pc_q;
    logic        bd_q;
    logic [4:0]  code_q;
    logic [31:0] badv_q;
    logic        eret_q;

    logic        ex_q;
    logic        erf_q;
    logic        we_q;
    logic [4:0]  addr_q;
    logic [31:0] wdata_q;
    logic [15:0] cnt_q;

    assign int_pend = status_ie & ~status_exl & (|(status_im & cause_ip));

    // Priority chain: flags may overlap, so the first match wins.
    always_comb begin
        has_exc = 1'b1;
        code_d  = 5'h00;
        badv_d  = 32'h0;
        if (int_pend) begin
            code_d = 5'h00;
        end else if (cm_adel_if) begin
            code_d = 5'h04;
            badv_d = cm_pc;
        end else if (cm_ri) begin
            code_d = 5'h0a;
        end else if (cm_ov) begin
            code_d = 5'h0c;
        end else if (cm_sys) begin
            code_d = 5'h08;
        end else if (cm_bp) begin
            code_d = 5'h09;
        end else if (cm_adel_ld) begin
            code_d = 5'h04;
            badv_d = cm_daddr;
        end else if (cm_ades_st) begin
            code_d = 5'h05;
            badv_d = cm_daddr;
        end else begin
            has_exc = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            pc_q    <= 32'h0;
            bd_q    <= 1'b0;
            code_q  <= 5'h0;
            badv_q  <= 32'h0;
            eret_q  <= 1'b0;
            ex_q    <= 1'b0;
            erf_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 5'h0;
            wdata_q <= 32'h0;
            cnt_q   <= 16'h0;
        end else begin
            ex_q    <= 1'b0;
            erf_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 5'h0;
            wdata_q <= 32'h0;
            if (ex_q && cnt_q != 16'hFFFF) begin
                cnt_q <= cnt_q + 16'd1;
            end
            case (state)
                IDLE: begin
                    if (cm_valid) begin
                        if (has_exc || cm_eret) begin
                            // eret only takes the eret path when no
                            // exception outranks it.
                            pc_q   <= cm_pc;
                            bd_q   <= cm_bd;
                            code_q <= code_d;
                            badv_q <= badv_d;
                            eret_q <= ~has_exc;
                            if (div_busy) begin
                                state <= WAIT_DIV;
                            end else begin
                                state <= FLUSH;
                                ex_q  <= has_exc;
                                erf_q <= ~has_exc;
                            end
                        end else if (cm_mtc0) begin
                            we_q    <= 1'b1;
                            addr_q  <= cm_cp0_addr;
                            wdata_q <= cm_cp0_wdata;
                        end
                    end
                end
                WAIT_DIV: begin
                    if (!div_busy) begin
                        state <= FLUSH;
                        ex_q  <= ~eret_q;
                        erf_q <= eret_q;
                    end
                end
                FLUSH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign cm_ready     = resetn & (state == IDLE);
    assign cp0_ex       = ex_q;
    assign eret_flush   = erf_q;
    assign cp0_excode   = ex_q ? code_q : 5'h0;
    assign cp0_bd       = ex_q & bd_q;
    assign cp0_pc       = ex_q ? pc_q : 32'h0;
    assign cp0_badvaddr = ex_q ? badv_q : 32'h0;
    assign cp0_we       = we_q;
    assign cp0_addr     = addr_q;
    assign cp0_wdata    = wdata_q;
    assign flush        = ex_q | erf_q;
    // EPC is taken live in the flush cycle so a late mtc0 to EPC is seen.
    assign flush_pc     = ex_q  ? EX_VEC :
                          erf_q ? epc_in : 32'h0;
    assign exc_cnt      = cnt_q;

endmodule
